// File: rtl/mem_access_unit.sv
// Load/store front-end for a byte-addressed, word-wide data memory: aligns requests,
// extends load data and performs read-modify-write for byte and halfword stores.
module mem_access_unit #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [31:0]   mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [DW-1:0] wdata_q;

    function automatic logic [31:0] word_addr(input logic [AW-1:0] a);
        logic [31:0] r;
        r = '0;
        r[AW-1:2] = a[AW-1:2];
        return r;
    endfunction

    function automatic logic bad_req(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{~uns & b[7]}}, b};
            2'b01:   return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Sub-word stores splice the new lane into the word just read back.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (bad_req(req_size, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && req_size == 2'b10) begin
                            state     <= WR;
                            mem_addr  <= word_addr(req_addr);
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_addr <= word_addr(req_addr);
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        state     <= WR;
                        mem_addr  <= word_addr(addr_q);
                        mem_we    <= 1'b1;
                        mem_wdata <= store_merge(mem_rdata, addr_q[1:0], size_q, wdata_q);
                    end else begin
                        state      <= RESP;
                        mem_addr   <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extract(mem_rdata, addr_q[1:0], size_q, uns_q);
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_addr   <= '0;
                    mem_we     <= 1'b0;
                    mem_wdata  <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge-write memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          we_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    int          errors;
    int          checks;

    mem_access_unit #(.AW(8), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            we_cnt = we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwe);
        int guard;
        int n0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        n0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        nwe = we_cnt - n0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwe;
    logic [8:0]  rdy_pat;
    int          nresp;
    int          w0;

    initial begin
        errors = 0; checks = 0; we_cnt = 0;
        last_waddr = '0; last_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        mem[4] = 32'h80FF7F01;
        do_req(1'b0, 2'b00, 1'b0, 8'h13, 32'h0, rd, er, lat, nwe);
        chk("lb_data", rd, 32'hFFFFFF80);
        chk("lb_lat", lat, 2);
        chk("lb_err", {31'b0, er}, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 8'h13, 32'h0, rd, er, lat, nwe);
        chk("lbu_data", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, rd, er, lat, nwe);
        chk("lh_data", rd, 32'hFFFF80FF);
        chk("lh_lat", lat, 2);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nwe);
        chk("lw_data", rd, 32'h80FF7F01);
        chk("lw_nwe", nwe, 0);

        mem[4] = 32'h11223344;
        do_req(1'b1, 2'b00, 1'b0, 8'h11, 32'h000000AB, rd, er, lat, nwe);
        chk("sb_lat", lat, 3);
        chk("sb_nwe", nwe, 1);
        chk("sb_wdata", last_wdata, 32'h1122AB44);
        chk("sb_waddr", last_waddr, 32'h00000010);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_err", {31'b0, er}, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nwe);
        chk("sb_readback", rd, 32'h1122AB44);

        mem[4] = 32'h11223344;
        do_req(1'b1, 2'b01, 1'b0, 8'h12, 32'h0000BEEF, rd, er, lat, nwe);
        chk("sh_lat", lat, 3);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nwe);
        chk("sh_readback", rd, 32'hBEEF3344);

        do_req(1'b1, 2'b10, 1'b0, 8'hFC, 32'hCAFEF00D, rd, er, lat, nwe);
        chk("sw_lat", lat, 2);
        chk("sw_nwe", nwe, 1);
        chk("sw_waddr", last_waddr, 32'h000000FC);
        do_req(1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, rd, er, lat, nwe);
        chk("sw_readback", rd, 32'hCAFEF00D);

        mem[8] = 32'h5A5A5A5A;
        do_req(1'b0, 2'b10, 1'b0, 8'h21, 32'h0, rd, er, lat, nwe);
        chk("lw_mis_err", {31'b0, er}, 32'h1);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_rdata", rd, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 8'h23, 32'h00001234, rd, er, lat, nwe);
        chk("sh_mis_err", {31'b0, er}, 32'h1);
        chk("sh_mis_lat", lat, 1);
        chk("sh_mis_nwe", nwe, 0);
        do_req(1'b1, 2'b11, 1'b0, 8'h20, 32'hFFFFFFFF, rd, er, lat, nwe);
        chk("ill_err", {31'b0, er}, 32'h1);
        chk("ill_rdata", rd, 32'h0);
        chk("ill_nwe", nwe, 0);
        chk("err_mem_intact", mem[8], 32'h5A5A5A5A);

        // Back-to-back: req_valid held high for nine edges starting in IDLE.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 8'h10;
        req_valid = 1'b1;
        nresp = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            rdy_pat[i] = req_ready;
            if (resp_valid) nresp++;
            @(posedge clk);
        end
        req_valid = 1'b0;
        #1;
        chk("b2b_ready_pattern", {23'b0, rdy_pat}, 32'h049);
        chk("b2b_resp_count", nresp, 3);
        chk("b2b_rdata", resp_rdata, 32'hBEEF3344);
        @(negedge clk);
        chk("idle_mem_addr", mem_addr, 32'h0);

        // Reset asserted during the WR cycle of a byte store, before the falling edge.
        mem[12] = 32'h11223344;
        w0 = we_cnt;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_addr = 8'h30; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwr_we_before", {31'b0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_we_drop", {31'b0, mem_we}, 32'h0);
        chk("rstwr_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) nresp++;
        end
        chk("rstwr_no_resp", nresp, 0);
        chk("rstwr_no_write", we_cnt - w0, 0);
        chk("rstwr_mem", mem[12], 32'h11223344);
        chk("rstwr_idle_ready", {31'b0, req_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end that sits directly upstream of the byte-addressed data memory.
- Accepts byte, halfword and word requests from the core and issues word-wide, word-aligned accesses to the memory.
  - Extracts and extends the returned data for loads.
  - Performs read-modify-write for sub-word stores, because the memory always writes 4 bytes per access.
  - Little-endian: the byte at offset k occupies bits [8k+7:8k].
- Flags misaligned or illegal requests instead of touching memory.

Parameters:
AW, 8, byte-address width used for the request (256-byte memory)
DW, 32, data width; fixed at 32, must match the memory data bus

Ports:
clk  input  1  clock; memory writes on its falling edge, this block's state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  AW  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  valid with resp_valid; 1 = misaligned or illegal size
mem_addr  output  32  word-aligned byte address to memory, zero-extended, low two bits always 0
mem_we  output  1  memory write enable
mem_wdata  output  32  word to write
mem_rdata  input  32  combinational memory read data for mem_addr

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we drops immediately, so no memory write occurs on any falling edge while reset is low, including when reset hits mid-WR.
  - Latched request fields are cleared.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1. A request is accepted on a rising edge with req_valid=1.
  - On accept, latch req_addr, req_we, req_size, req_unsigned, req_wdata.
  - Error check on accept:
    - size 11 → error.
    - size 01 with addr[0]=1 → error.
    - size 10 with addr[1:0]≠00 → error.
  - Transitions on accept:
    - Error → RESP with err=1; no memory access is made.
    - Store word → WR.
    - Anything else → RD.
- RD:
  - mem_addr = {addr[AW-1:2],2'b00}, zero-extended; mem_we=0.
  - On the rising edge, capture mem_rdata into the word buffer.
  - Load → RESP, with resp_rdata computed from the buffer:
    - Byte: select byte addr[1:0], then extend.
    - Halfword: select halfword addr[1], then extend.
    - Word: pass through.
  - Sub-word store → WR.
- WR:
  - mem_addr is the aligned address; mem_we=1 for exactly this one cycle, so the memory writes on its falling edge.
  - mem_wdata for a word store = latched wdata.
  - mem_wdata for a byte store = buffer with byte lane addr[1:0] replaced by wdata[7:0].
  - mem_wdata for a halfword store = buffer with halfword lane addr[1] replaced by wdata[15:0].
  - Always → RESP.
- RESP:
  - resp_valid=1 for one cycle; req_ready=0.
  - resp_rdata is held from RD for loads; 0 for stores and errors.
  - Always → IDLE.
  - resp_valid and resp_err are 0 in every other state. resp_rdata holds its last value outside RESP.
- Latency, accept edge to resp_valid high:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB or SH: 3 cycles.
  - Throughput is one request per latency+1 cycles, since IDLE is re-entered before the next accept.
- req_valid outside IDLE is ignored, and request inputs may change freely then.
- The last word (aligned address AW'hFC) is legal.
- mem_addr is 0 in IDLE and RESP; mem_wdata is 0 except in WR.

Test Plan:
- Reset mid-SB:
  - Stimulus: assert rst_n=0 during WR, before the falling edge.
  - Required: mem_we goes low at once, the memory word is unchanged, the block is in IDLE with req_ready=1, and no resp_valid follows.
- Loads from a word preloaded with 0x80FF7F01 at address 0x10:
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80FF.
  - LW 0x10 → 0x80FF7F01.
  - Each resp_valid arrives 2 cycles after accept with err=0.
- SB 0xAB to 0x11 over a word of 0x11223344:
  - Required: one RD cycle, then a WR cycle with mem_wdata=0x1122AB44 and exactly one mem_we cycle, then resp_valid with rdata=0.
  - A follow-up LW 0x10 returns 0x1122AB44.
- SH 0xBEEF to 0x12 → word becomes 0xBEEF3344. SW 0xCAFEF00D to 0xFC → LW 0xFC returns 0xCAFEF00D, with the store completing in 2 cycles.
- Misaligned and illegal requests: LW 0x21, SH 0x23, size=11 at 0x20.
  - Each returns resp_err=1, rdata=0, 1 cycle after accept.
  - mem_we never asserts and memory is unchanged.
- Back-to-back requests: hold req_valid=1 continuously.
  - Required: req_ready is low from accept through RESP, only one request is accepted per transaction, and the next request is accepted on the first IDLE edge.
